// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared opcodes, register map, status bits and FSM encoding for accel_alu_seq
package accel_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;

    localparam logic [3:0] ADDR_A0     = 4'h0;
    localparam logic [3:0] ADDR_A1     = 4'h1;
    localparam logic [3:0] ADDR_B0     = 4'h2;
    localparam logic [3:0] ADDR_B1     = 4'h3;
    localparam logic [3:0] ADDR_OP     = 4'h4;
    localparam logic [3:0] ADDR_STATUS = 4'h6;
    localparam logic [3:0] ADDR_CTRL   = 4'h7;
    localparam logic [3:0] ADDR_RES0   = 4'h8;
    localparam logic [3:0] ADDR_RES1   = 4'h9;
    localparam logic [3:0] ADDR_RES2   = 4'hA;
    localparam logic [3:0] ADDR_RES3   = 4'hB;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_DZ      = 2;
    localparam int ST_IE      = 3;
    localparam int CTRL_START = 0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/accel_muldiv_iter.sv
// rtl/accel_muldiv_iter.sv - iterative shift-add multiplier / restoring divider, one step per clock
module accel_muldiv_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 op_is_div_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 dz_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic                busy_q, busy_d;
    logic                div_q, div_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    m_q, m_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [2*WIDTH-1:0]  step;
    logic [WIDTH:0]      mul_sum, rem_sh, rem_sub;
    logic                last;

    // acc holds {high, low}: MUL {partial product, remaining multiplier};
    // DIV {partial remainder, dividend bits shifting into quotient}
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
        rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
        rem_sub = rem_sh - {1'b0, m_q};
        if (div_q) begin
            if (rem_sh >= {1'b0, m_q}) begin
                step = {rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    assign last = busy_q && (cnt_q == LAST);

    always_comb begin
        busy_d = busy_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        m_d    = m_q;
        acc_d  = acc_q;
        if (start_i) begin
            busy_d = 1'b1;
            div_d  = op_is_div_i;
            cnt_d  = '0;
            m_d    = op_is_div_i ? b_i : a_i;
            acc_d  = {{WIDTH{1'b0}}, (op_is_div_i ? a_i : b_i)};
        end else if (busy_q) begin
            acc_d = step;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            m_q    <= '0;
            acc_q  <= '0;
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            m_q    <= m_d;
            acc_q  <= acc_d;
        end
    end

    // Divide by zero needs no special path: every trial subtract succeeds,
    // giving an all-ones quotient and the dividend as remainder.
    assign busy_o   = busy_q;
    assign done_o   = last;
    assign result_o = step;
    assign dz_o     = div_q && (m_q == '0);

endmodule

// File: rtl/accel_alu_seq.sv
// rtl/accel_alu_seq.sv - byte-bus ALU peripheral with start/busy/done handshake; optional IRQ via ACCEL_IRQ_EN
module accel_alu_seq
    import accel_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
`ifdef ACCEL_IRQ_EN
    ,
    output logic       user_interrupt
`endif
);
    localparam int W2 = 2 * WIDTH;

    if (WIDTH != 8 && WIDTH != 16) begin : g_width_check
        $error("accel_alu_seq: WIDTH must be 8 or 16");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [3:0]        op_q, op_d;
    logic [W2-1:0]     res_q, res_d;
    logic              done_q, done_d, dz_q, dz_d;
    logic              ie_rd;
    logic [15:0]       a_wr, b_wr, a_rd, b_rd;
    logic [31:0]       res_rd;
    logic [WIDTH:0]    add_r, sub_r;
    logic [W2-1:0]     alu_res, md_res;
    logic              start_acc, is_muldiv, md_busy, md_done, md_dz;
    logic              unused_ui;

`ifdef ACCEL_IRQ_EN
    logic ie_q, ie_d, irq_q;
    assign ie_rd = ie_q;
`else
    assign ie_rd = 1'b0;
`endif

    assign unused_ui = ^ui_in;
    assign uo_out    = 8'h00;

    assign start_acc = data_write && (address == ADDR_CTRL) && data_in[CTRL_START]
                       && (state_q == S_IDLE);
    assign is_muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);

    accel_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_acc && is_muldiv),
        .op_is_div_i (op_q == OP_DIV),
        .a_i         (a_q),
        .b_i         (b_q),
        .busy_o      (md_busy),
        .done_o      (md_done),
        .result_o    (md_res),
        .dz_o        (md_dz)
    );

    always_comb begin
        add_r = {1'b0, a_q} + {1'b0, b_q};
        sub_r = {1'b0, a_q} - {1'b0, b_q};
        case (op_q)
            OP_ADD:  alu_res = W2'(add_r);
            OP_SUB:  alu_res = W2'(sub_r);
            OP_AND:  alu_res = W2'(a_q & b_q);
            OP_OR:   alu_res = W2'(a_q | b_q);
            OP_XOR:  alu_res = W2'(a_q ^ b_q);
            default: alu_res = '0;
        endcase
    end

    // Registers are edited through 16-bit views so bytes above WIDTH drop out naturally.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        res_d   = res_q;
        done_d  = done_q;
        dz_d    = dz_q;
        a_wr    = 16'(a_q);
        b_wr    = 16'(b_q);
`ifdef ACCEL_IRQ_EN
        ie_d    = ie_q;
`endif
        if (data_write) begin
            case (address)
                ADDR_A0: a_wr[7:0]  = data_in;
                ADDR_A1: a_wr[15:8] = data_in;
                ADDR_B0: b_wr[7:0]  = data_in;
                ADDR_B1: b_wr[15:8] = data_in;
                ADDR_OP: op_d       = data_in[3:0];
                ADDR_STATUS: begin
                    if (data_in[ST_DONE]) done_d = 1'b0;
`ifdef ACCEL_IRQ_EN
                    ie_d = data_in[ST_IE];
`endif
                end
                default: ;
            endcase
        end
        a_d = a_wr[WIDTH-1:0];
        b_d = b_wr[WIDTH-1:0];

        // Evaluated after the W1C so a completion on the same edge keeps done set
        case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    done_d = 1'b0;
                    dz_d   = 1'b0;
                    if (is_muldiv) begin
                        state_d = S_RUN;
                    end else begin
                        res_d  = alu_res;
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (md_done) begin
                    state_d = S_IDLE;
                    res_d   = md_res;
                    done_d  = 1'b1;
                    dz_d    = md_dz;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

`ifdef ACCEL_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= done_q & ie_q;
        end
    end
    assign user_interrupt = irq_q;
`endif

    assign a_rd   = 16'(a_q);
    assign b_rd   = 16'(b_q);
    assign res_rd = 32'(res_q);

    always_comb begin
        case (address)
            ADDR_A0:     data_out = a_rd[7:0];
            ADDR_A1:     data_out = a_rd[15:8];
            ADDR_B0:     data_out = b_rd[7:0];
            ADDR_B1:     data_out = b_rd[15:8];
            ADDR_OP:     data_out = {4'b0000, op_q};
            ADDR_STATUS: data_out = {4'b0000, ie_rd, dz_q, done_q, md_busy};
            ADDR_RES0:   data_out = res_rd[7:0];
            ADDR_RES1:   data_out = res_rd[15:8];
            ADDR_RES2:   data_out = res_rd[23:16];
            ADDR_RES3:   data_out = res_rd[31:24];
            default:     data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_accel_alu_seq.sv
// tb/tb_accel_alu_seq.sv - self-checking bench for accel_alu_seq (WIDTH 8 and 16; ACCEL_IRQ_EN aware)
module tb_accel_alu_seq;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] ui_tb;
    logic [3:0] addr8, addr16;
    logic       wr8, wr16;
    logic [7:0] din8, din16, dout8, dout16, uo8, uo16;
`ifdef ACCEL_IRQ_EN
    logic       irq8, irq16;
`endif

    accel_alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_tb), .uo_out(uo8),
        .address(addr8), .data_write(wr8), .data_in(din8), .data_out(dout8)
`ifdef ACCEL_IRQ_EN
        , .user_interrupt(irq8)
`endif
    );

    accel_alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_tb), .uo_out(uo16),
        .address(addr16), .data_write(wr16), .data_in(din16), .data_out(dout16)
`ifdef ACCEL_IRQ_EN
        , .user_interrupt(irq16)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // Reference model of the 8-bit instance: user registers plus a countdown to completion
    logic [7:0]  m_a = 8'h00, m_b = 8'h00;
    logic [3:0]  m_op = 4'h0;
    logic [15:0] m_res = 16'h0000, m_pres = 16'h0000;
    bit          m_done = 0, m_dz = 0, m_pdz = 0, m_ie = 0, m_irq = 0;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin : model
        int ia, ib;
        bit was_idle, fin;
        if (!rst_n) begin
            m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_pres = 0;
            m_done = 0; m_dz = 0; m_pdz = 0; m_ie = 0; m_irq = 0; m_left = 0;
        end else begin
            ia = int'(m_a);
            ib = int'(m_b);
            was_idle = (m_left == 0);
            fin = 0;
            m_irq = m_done & m_ie;
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_res = m_pres; m_done = 1; m_dz = m_pdz; fin = 1;
                end
            end
            if (wr8) begin
                case (addr8)
                    4'h0: m_a = din8;
                    4'h2: m_b = din8;
                    4'h4: m_op = din8[3:0];
                    4'h6: begin
                        if (din8[1] && !fin) m_done = 0;
`ifdef ACCEL_IRQ_EN
                        m_ie = din8[3];
`endif
                    end
                    default: ;
                endcase
            end
            if (wr8 && addr8 == 4'h7 && din8[0] && was_idle) begin
                m_done = 0; m_dz = 0;
                case (m_op)
                    4'd0: begin m_res = 16'(ia + ib); m_done = 1; end
                    4'd1: begin m_res = 16'((ia - ib) & 'h1FF); m_done = 1; end
                    4'd2: begin m_pres = 16'(ia * ib); m_pdz = 0; m_left = 8; end
                    4'd3: begin
                        m_left = 8;
                        m_pdz  = (ib == 0);
                        m_pres = (ib == 0) ? 16'((ia << 8) | 'hFF)
                                           : 16'(((ia % ib) << 8) | (ia / ib));
                    end
                    4'd4: begin m_res = 16'(ia & ib); m_done = 1; end
                    4'd5: begin m_res = 16'(ia | ib); m_done = 1; end
                    4'd6: begin m_res = 16'(ia ^ ib); m_done = 1; end
                    default: begin m_res = 16'h0000; m_done = 1; end
                endcase
            end
        end
    end

    function automatic logic [7:0] exp_rd(input logic [3:0] a);
        case (a)
            4'h0:    return m_a;
            4'h2:    return m_b;
            4'h4:    return {4'b0000, m_op};
            4'h6:    return {4'b0000, m_ie, m_dz, m_done, (m_left > 0)};
            4'h8:    return m_res[7:0];
            4'h9:    return m_res[15:8];
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge clk) begin : compare
        logic [7:0] e;
        if (chk_on) begin
            e = exp_rd(addr8);
            n_cmp++;
            if (dout8 !== e) begin
                n_fail++;
                $display("FAIL model_rd addr=%h got=%h exp=%h t=%0t", addr8, dout8, e, $time);
            end
            n_cmp++;
            if (uo8 !== 8'h00 || uo16 !== 8'h00) begin
                n_fail++;
                $display("FAIL uo_out got=%h/%h exp=00", uo8, uo16);
            end
`ifdef ACCEL_IRQ_EN
            n_cmp++;
            if (irq8 !== m_irq) begin
                n_fail++;
                $display("FAIL model_irq got=%b exp=%b t=%0t", irq8, m_irq, $time);
            end
`endif
        end
    end

    task automatic wr(input bit w16, input logic [3:0] a, input logic [7:0] d);
        if (w16) begin addr16 = a; din16 = d; wr16 = 1'b1; end
        else     begin addr8  = a; din8  = d; wr8  = 1'b1; end
        @(posedge clk); #1;
        wr8 = 1'b0;
        wr16 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input bit w16, input logic [3:0] a, input logic [7:0] exp, input string nm);
        logic [7:0] got;
        if (w16) addr16 = a; else addr8 = a;
        @(negedge clk);
        got = w16 ? dout16 : dout8;
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic busy_cycles(input bit w16, output int n);
        logic [7:0] s;
        if (w16) addr16 = 4'h6; else addr8 = 4'h6;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            s = w16 ? dout16 : dout8;
            if (!s[0]) break;
            n++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic num_chk(input int got, input int exp, input string nm);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        wr(0, 4'h0, a);
        wr(0, 4'h2, b);
        wr(0, 4'h4, {4'b0000, op});
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        rst_n = 1'b0; ui_tb = 8'hA5;
        addr8 = 0; wr8 = 0; din8 = 0;
        addr16 = 0; wr16 = 0; din16 = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_on = 1'b1;

        rd_chk(0, 4'h6, 8'h00, "reset_status");
        rd_chk(0, 4'h8, 8'h00, "reset_res0");
        rd_chk(0, 4'h0, 8'h00, "reset_a");

        load(8'hC8, 8'h03, 4'd2);
        wr(0, 4'h7, 8'h01);
        busy_cycles(0, n);
        num_chk(n, 8, "mul8_busy_cycles");
        rd_chk(0, 4'h8, 8'h58, "mul8_res0");
        rd_chk(0, 4'h9, 8'h02, "mul8_res1");
        rd_chk(0, 4'h6, 8'h02, "mul8_status");

        load(8'd100, 8'd7, 4'd3);
        wr(0, 4'h7, 8'h01);
        idle(9);
        rd_chk(0, 4'h8, 8'h0E, "div_quot");
        rd_chk(0, 4'h9, 8'h02, "div_rem");
        rd_chk(0, 4'h6, 8'h02, "div_status");

        load(8'h2A, 8'h00, 4'd3);
        wr(0, 4'h7, 8'h01);
        idle(9);
        rd_chk(0, 4'h8, 8'hFF, "divz_quot");
        rd_chk(0, 4'h9, 8'h2A, "divz_rem");
        rd_chk(0, 4'h6, 8'h06, "divz_status");

        load(8'hFF, 8'h01, 4'd0);
        wr(0, 4'h7, 8'h01);
        rd_chk(0, 4'h6, 8'h02, "add_status");
        rd_chk(0, 4'h8, 8'h00, "add_res0");
        rd_chk(0, 4'h9, 8'h01, "add_res1");

        load(8'h05, 8'h07, 4'd1);
        wr(0, 4'h7, 8'h01);
        rd_chk(0, 4'h8, 8'hFE, "sub_res0");
        rd_chk(0, 4'h9, 8'h01, "sub_res1");

        load(8'h11, 8'h0F, 4'd2);
        wr(0, 4'h7, 8'h01);
        wr(0, 4'h0, 8'h00);
        wr(0, 4'h7, 8'h01);
        idle(8);
        rd_chk(0, 4'h8, 8'hFF, "restart_res0");
        rd_chk(0, 4'h9, 8'h00, "restart_res1");
        rd_chk(0, 4'h0, 8'h00, "restart_user_a");
        wr(0, 4'h6, 8'h02);
        rd_chk(0, 4'h6, 8'h00, "w1c_status");

        wr(1, 4'h0, 8'hFF); wr(1, 4'h1, 8'hFF);
        wr(1, 4'h2, 8'hFF); wr(1, 4'h3, 8'hFF);
        wr(1, 4'h4, 8'h02);
        wr(1, 4'h7, 8'h01);
        busy_cycles(1, n);
        num_chk(n, 16, "mul16_busy_cycles");
        rd_chk(1, 4'h8, 8'h01, "mul16_res0");
        rd_chk(1, 4'h9, 8'h00, "mul16_res1");
        rd_chk(1, 4'hA, 8'hFE, "mul16_res2");
        rd_chk(1, 4'hB, 8'hFF, "mul16_res3");
        rd_chk(1, 4'h6, 8'h02, "mul16_status");

        load(8'd100, 8'd7, 4'd3);
        wr(0, 4'h7, 8'h01);
        idle(3);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        rd_chk(0, 4'h6, 8'h00, "rst_status");
        rd_chk(0, 4'h8, 8'h00, "rst_res0");
        rd_chk(0, 4'h4, 8'h00, "rst_op");

`ifdef ACCEL_IRQ_EN
        begin : irq_test
            int d_at, i_at;
            wr(0, 4'h6, 8'h08);
            load(8'd3, 8'd4, 4'd2);
            wr(0, 4'h7, 8'h01);
            addr8 = 4'h6;
            d_at = -1; i_at = -1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (d_at < 0 && dout8[1]) d_at = i;
                if (i_at < 0 && irq8) i_at = i;
                @(posedge clk); #1;
                if (i_at >= 0) break;
            end
            num_chk(i_at - d_at, 1, "irq_delay");
            rd_chk(0, 4'h8, 8'h0C, "irq_mul_res0");
            wr(0, 4'h6, 8'h0A);
            idle(1);
            @(negedge clk);
            num_chk(int'(irq8), 0, "irq_cleared");
            @(posedge clk); #1;
        end
`endif

        for (int it = 0; it < 80; it++) begin
            logic [7:0] rb;
            logic [3:0] rop;
            rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            rop = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 6));
            wr(0, 4'h1, 8'($urandom));
            load(8'($urandom), rb, rop);
            wr(0, 4'h7, 8'h01);
            for (int k = 0; k < int'($urandom_range(0, 12)); k++) begin
                if ($urandom_range(0, 2) == 0) wr(0, 4'($urandom), 8'($urandom));
                else begin
                    addr8 = 4'($urandom);
                    idle(1);
                end
            end
            addr8 = 4'h8;
            idle(9);
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/accel_alu_seq.md
Name: accel_alu_seq

Overview:
Parametrised successor to the single-cycle TinyQV math peripheral. It adds configurable operand width and a start/busy/done handshake with a status register. MUL and DIV run on an iterative engine that takes WIDTH cycles. Operands are latched at start, so software may reload A/B during a run. It sits behind the TinyQV peripheral byte bus (4-bit address, 8-bit data).

Parameters:
WIDTH, 8, operand width in bits. Legal values are 8 or 16; any other value must abort elaboration with a generate-time error.

Ports:
clk  input  1  clock (64 MHz nominal)
rst_n  input  1  reset; asynchronous, active-low
ui_in  input  8  input PMOD; unused
uo_out  output  8  output PMOD; tied to 0
address  input  4  register address
data_write  input  1  write strobe; data_in valid
data_in  input  8  write data
data_out  output  8  read data (combinational from address)
user_interrupt  output  1  present only with ACCEL_IRQ_EN

Behaviour:
- Register map:
  - 0x0/0x1 A bytes [7:0]/[15:8]
  - 0x2/0x3 B bytes
  - 0x4 OP [3:0], reads {4'b0, op}
  - 0x6 STATUS: bit0 busy (RO), bit1 done (W1C), bit2 dz (RO), bit3 ie (RW, IRQ build only)
  - 0x7 CTRL: bit0 start, write-only, reads 0
  - 0x8..0xB RESULT bytes 0..3
- Bytes beyond WIDTH or 2*WIDTH read 0 and ignore writes. Unmapped addresses read 0.
- Reset: A, B, OP, RESULT, busy, done, dz, ie all 0; FSM in IDLE; data_out follows the address map; uo_out=0.
- FSM states: IDLE, RUN.
- Start qualifier: start is accepted at edge P when data_write, address=0x7, data_in[0]=1 and state=IDLE. Start while RUN is ignored with no side effects.
- On accepted start at P:
  - Latch A, B, OP into working registers.
  - Clear done and dz.
  - Single-cycle ops: RESULT written and done=1 at P; busy is never visible.
  - MUL/DIV: state RUN, busy=1, counter=0. One shift-add or restoring-subtract step per edge.
  - After edge P+WIDTH: RESULT written, done=1, busy=0, state IDLE.
- Opcodes (arithmetic modulo the stated widths):
  - 0 ADD: {carry, A+B}
  - 1 SUB: bit WIDTH=borrow, low WIDTH bits A-B
  - 2 MUL: unsigned 2*WIDTH product
  - 3 DIV: quotient in low WIDTH bits, remainder in high WIDTH bits
  - 4 AND, 5 OR, 6 XOR: zero-extended
  - 7..15: result 0, done=1
- DIV by zero: quotient all-ones, remainder=A, dz=1. Still takes WIDTH cycles.
- RESULT holds its previous value during RUN and changes only on completion.
- Writes to A/B/OP during RUN update the user registers only. The run in flight is unaffected.
- W1C to done on the completion edge: set wins.
- Reset mid-RUN: immediate return to reset state; no completion.

Optional Feature:
ACCEL_IRQ_EN
- Defined:
  - Adds the user_interrupt port and the STATUS.ie bit.
  - user_interrupt = registered (done & ie); it deasserts the edge after done is cleared by W1C or by a new start.
- Undefined:
  - No user_interrupt port.
  - STATUS bit3 reads 0; writes to it are ignored.

Decomposition:
- Package accel_pkg holds:
  - opcode localparams (OP_ADD..OP_XOR)
  - register address localparams
  - STATUS bit indices
  - FSM state encoding
- Sub-module accel_muldiv_iter, parametrised by WIDTH:
  - Inputs: start, op_is_div, a, b.
  - Outputs: busy, done pulse, result[2*WIDTH-1:0], dz.
  - Contains the step counter and the shift/accumulate datapath.
- The top level holds the register file, single-cycle ops and the read mux.

Test Plan:
- WIDTH=8, A=0xC8, B=0x03, OP=2, start -> busy=1 for 8 cycles; then done=1, 0x8=0x58, 0x9=0x02.
- WIDTH=8, DIV 100/7 -> 0x8=0x0E, 0x9=0x02, dz=0. DIV 0x2A/0 -> 0x8=0xFF, 0x9=0x2A, dz=1.
- WIDTH=8, ADD 0xFF+0x01 -> STATUS=0x02 on the next read, RESULT=0x0100. SUB 0x05-0x07 -> 0x8=0xFE, 0x9=0x01.
- MUL running; write A=0, write start again -> start ignored, RESULT matches the original operands. Then write STATUS=0x02 -> done=0.
- WIDTH=16, MUL 0xFFFF*0xFFFF -> 16 busy cycles, RESULT bytes 0x01,0x00,0xFE,0xFF.
- Assert rst_n low mid-DIV -> STATUS=0, RESULT=0, FSM IDLE. IRQ build with ie=1, MUL 3*4 -> user_interrupt rises one cycle after done; W1C of done drops it.
